// File: rtl/simon_pkg.sv
// Shared types and constants for the Simon Says sequence memory clients
// (main FSM, playback engine, player validator).
package simon_pkg;

  localparam int SIMON_DEPTH = 10;
  localparam int SIMON_IDX_W = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ON,
    ST_OFF,
    ST_DONE
  } playback_state_t;

  typedef logic [1:0] color_t;

  function automatic logic [3:0] color_onehot(color_t c);
    return 4'b0001 << c;
  endfunction

endpackage

// File: rtl/simon_tick_gen.sv
// TICK_DIV prescaler: one-cycle tick strobe, realigned by clr so every
// display phase starts with a full tick period.
module simon_tick_gen #(
  parameter int TICK_DIV = 1
) (
  input  logic gclk,
  input  logic grst_n,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [CNT_W-1:0] cnt;

  assign tick = (cnt == CNT_W'(TICK_DIV - 1));

  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n)          cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/simon_playback.sv
// Sequence playback: reads the color sequence entry by entry and flashes
// each color on the LEDs with fixed on/off durations.
module simon_playback
  import simon_pkg::*;
#(
  parameter int TICK_DIV  = 1,
  parameter int ON_TICKS  = 4,
  parameter int OFF_TICKS = 2,
  parameter int DEPTH     = SIMON_DEPTH,
  parameter int IDX_W     = SIMON_IDX_W
) (
  input  logic             CLOCK_50,
  input  logic             resetn,
  input  logic             start,
  input  logic [IDX_W-1:0] length,
  output logic [IDX_W-1:0] rd_addr,
  input  logic [1:0]       rd_data,
  output logic [3:0]       led,
  output logic             busy,
  output logic             done
);

  localparam int MAX_TICKS = (ON_TICKS > OFF_TICKS) ? ON_TICKS : OFF_TICKS;
  localparam int DUR_W     = $clog2(MAX_TICKS * TICK_DIV + 1);

  playback_state_t  state, state_d;
  logic [IDX_W-1:0] idx, len_q;
  color_t           color_q;
  logic [DUR_W-1:0] dur;
  logic             tick, on_end, off_end, last;
  logic             accept, zero_req, zero_done_q, phase_chg;

  assign accept    = (state == ST_IDLE) && start && (length != '0);
  assign zero_req  = (state == ST_IDLE) && start && (length == '0);
  assign on_end    = tick && (dur == DUR_W'(ON_TICKS - 1));
  assign off_end   = tick && (dur == DUR_W'(OFF_TICKS - 1));
  assign last      = (idx == len_q - 1'b1);
  assign phase_chg = (state_d != state);
  assign rd_addr   = idx;

  simon_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .gclk  (CLOCK_50),
    .grst_n(resetn),
    .clr   (phase_chg),
    .tick  (tick)
  );

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) state <= ST_IDLE;
    else         state <= state_d;
  end

  always_comb begin
    state_d = state;
    case (state)
      ST_IDLE:  if (accept) state_d = ST_FETCH;
      ST_FETCH: state_d = ST_ON;
      ST_ON:    if (on_end) state_d = ST_OFF;
      ST_OFF:   if (off_end) state_d = last ? ST_DONE : ST_FETCH;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Zero-length requests report done without ever leaving IDLE.
  always_comb begin
    led  = '0;
    busy = 1'b0;
    done = zero_done_q;
    case (state)
      ST_IDLE:  ;
      ST_ON:    begin led = color_onehot(color_q); busy = 1'b1; end
      ST_DONE:  begin busy = 1'b1; done = 1'b1; end
      default:  busy = 1'b1;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      idx         <= '0;
      len_q       <= '0;
      color_q     <= '0;
      dur         <= '0;
      zero_done_q <= 1'b0;
    end else begin
      zero_done_q <= zero_req;
      if (phase_chg)                                    dur <= '0;
      else if (tick && (state == ST_ON || state == ST_OFF)) dur <= dur + 1'b1;
      if (accept) begin
        len_q <= (length > IDX_W'(DEPTH)) ? IDX_W'(DEPTH) : length;
        idx   <= '0;
      end
      if (state == ST_FETCH)                 color_q <= rd_data;
      if (state == ST_OFF && off_end && !last) idx   <= idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_simon_playback.sv
// Randomized + directed bench: two instances (TICK_DIV 1 and 3) checked every
// cycle against a closed-form timing model of the playback schedule.
module tb_simon_playback;

  localparam int ON = 4, OFF = 2, DEP = 10;

  int D [2] = '{1, 3};

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic [1:0]      start_i = '0;
  logic [1:0][3:0] length_i = '0;
  logic [1:0][3:0] rd_addr_o;
  logic [1:0][1:0] rd_data_i;
  logic [1:0][3:0] led_o;
  logic [1:0]      busy_o, done_o;
  logic [1:0]      mem [2][16];

  int cyc = 0, total = 0, bad = 0;
  int pk [2], plen [2], zdone [2], done_at [2], lit [2];
  int k;

  always #5 clk = ~clk;

  assign rd_data_i[0] = mem[0][rd_addr_o[0]];
  assign rd_data_i[1] = mem[1][rd_addr_o[1]];

  simon_playback #(.TICK_DIV(1)) dut0 (
    .CLOCK_50(clk), .resetn(resetn), .start(start_i[0]), .length(length_i[0]),
    .rd_addr(rd_addr_o[0]), .rd_data(rd_data_i[0]), .led(led_o[0]),
    .busy(busy_o[0]), .done(done_o[0])
  );

  simon_playback #(.TICK_DIV(3)) dut1 (
    .CLOCK_50(clk), .resetn(resetn), .start(start_i[1]), .length(length_i[1]),
    .rd_addr(rd_addr_o[1]), .rd_data(rd_data_i[1]), .led(led_o[1]),
    .busy(busy_o[1]), .done(done_o[1])
  );

  task automatic chk(input string tag, input int u, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s u%0d cyc=%0d got=%0h exp=%0h", tag, u, cyc, got, exp);
    end
  endtask

  // Schedule of an accepted play of L entries started at cycle k:
  // entry e occupies cycles k+1+e*P .. k+(e+1)*P, done at k+1+L*P.
  function automatic int per(input int u);
    return 1 + (ON + OFF) * D[u];
  endfunction

  function automatic int pend(input int u);
    return pk[u] + 1 + plen[u] * per(u);
  endfunction

  function automatic bit idle(input int u, input int c);
    return !(plen[u] > 0 && c >= pk[u] + 1 && c <= pend(u));
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      pk[u] = -1000; plen[u] = 0; zdone[u] = -1;
    end
  endtask

  task automatic check_outputs();
    for (int u = 0; u < 2; u++) begin
      int el, eb, ed, ea, off, e, r;
      el = 0; eb = 0; ed = 0;
      ea = (plen[u] > 0) ? plen[u] - 1 : 0;
      if (plen[u] > 0 && cyc >= pk[u] + 1 && cyc < pend(u)) begin
        off = cyc - pk[u] - 1; e = off / per(u); r = off % per(u);
        eb = 1; ea = e;
        if (r >= 1 && r <= ON * D[u]) el = 1 << mem[u][e];
      end else if (plen[u] > 0 && cyc == pend(u)) begin
        eb = 1; ed = 1;
      end else begin
        ed = (cyc == zdone[u]) ? 1 : 0;
      end
      if (done_o[u] === 1'b1 && done_at[u] < 0) done_at[u] = cyc;
      if (led_o[u] != 4'b0) lit[u]++;
      chk("led",  u, 32'(led_o[u]),    el);
      chk("busy", u, 32'(busy_o[u]),   eb);
      chk("done", u, 32'(done_o[u]),   ed);
      chk("addr", u, 32'(rd_addr_o[u]), ea);
    end
  endtask

  task automatic model_update();
    for (int u = 0; u < 2; u++)
      if (resetn && start_i[u] && idle(u, cyc)) begin
        if (length_i[u] != 4'd0) begin
          pk[u] = cyc;
          plen[u] = (int'(length_i[u]) > DEP) ? DEP : int'(length_i[u]);
        end else zdone[u] = cyc + 1;
      end
  endtask

  task automatic cycle();
    @(negedge clk); check_outputs();
    @(posedge clk); model_update(); cyc++;
    #1;
  endtask

  task automatic go(input int u, input int len, input int n, output int ks);
    while (!idle(u, cyc)) cycle();
    done_at[u] = -1; lit[u] = 0; ks = cyc;
    start_i[u] = 1'b1; length_i[u] = 4'(len);
    cycle();
    start_i[u] = 1'b0; length_i[u] = 4'($urandom);
    repeat (n) cycle();
  endtask

  initial begin
    model_reset();
    done_at = '{-1, -1}; lit = '{0, 0};
    for (int u = 0; u < 2; u++) for (int i = 0; i < 16; i++) mem[u][i] = 2'b00;
    #3;
    for (int u = 0; u < 2; u++) begin
      chk("rst_led",  u, 32'(led_o[u]),    0);
      chk("rst_busy", u, 32'(busy_o[u]),   0);
      chk("rst_done", u, 32'(done_o[u]),   0);
      chk("rst_addr", u, 32'(rd_addr_o[u]), 0);
    end
    cycle(); cycle();
    resetn = 1'b1;
    cycle();

    // single entry, code 10 -> LEDR[2]
    mem[0][0] = 2'b10;
    go(0, 1, 10, k);
    chk("s1_done", 0, done_at[0] - k, 8);
    chk("s1_lit",  0, lit[0], 4);

    // two entries {10, 00}
    mem[0][0] = 2'b10; mem[0][1] = 2'b00;
    go(0, 2, 16, k);
    chk("s2_done", 0, done_at[0] - k, 15);
    chk("s2_lit",  0, lit[0], 8);

    // zero length
    go(0, 0, 4, k);
    chk("s3_done", 0, done_at[0] - k, 1);
    chk("s3_lit",  0, lit[0], 0);

    // start during ON of a 3-entry play is ignored
    for (int i = 0; i < 16; i++) mem[0][i] = 2'($urandom);
    go(0, 3, 3, k);
    start_i[0] = 1'b1; length_i[0] = 4'd5;
    cycle();
    start_i[0] = 1'b0;
    repeat (24) cycle();
    chk("s4_done", 0, done_at[0] - k, 22);
    chk("s4_lit",  0, lit[0], 12);

    // length 15 clamps to 10 entries
    go(0, 15, 75, k);
    chk("s4_clamp_done", 0, done_at[0] - k, 71);
    chk("s4_clamp_lit",  0, lit[0], 40);

    // divider instance
    mem[1][0] = 2'b01;
    go(1, 1, 24, k);
    chk("s6_done", 1, done_at[1] - k, 20);
    chk("s6_lit",  1, lit[1], 12);

    // random traffic on both instances, including starts while busy
    repeat (3000) begin
      for (int u = 0; u < 2; u++) begin
        start_i[u]  = ($urandom % 8) == 0;
        length_i[u] = 4'($urandom);
        if (idle(u, cyc) && ($urandom % 4) == 0)
          for (int i = 0; i < 16; i++) mem[u][i] = 2'($urandom);
      end
      cycle();
    end
    start_i = '0;

    // reset during OFF of entry 1
    for (int i = 0; i < 16; i++) mem[0][i] = 2'($urandom);
    go(0, 3, 12, k);
    #2 resetn = 1'b0;
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("arst_led",  u, 32'(led_o[u]),    0);
      chk("arst_busy", u, 32'(busy_o[u]),   0);
      chk("arst_done", u, 32'(done_o[u]),   0);
      chk("arst_addr", u, 32'(rd_addr_o[u]), 0);
    end
    model_reset();
    cycle(); cycle();
    resetn = 1'b1;
    cycle();
    mem[0][0] = 2'b11; mem[0][1] = 2'b01;
    go(0, 2, 16, k);
    chk("post_rst_done", 0, done_at[0] - k, 15);
    chk("post_rst_lit",  0, lit[0], 8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
